// File: rtl/uart_tx_fifo_if.sv
// Bus-side and UART-side signal bundle for the UART transmit FIFO.
// master: the environment (bus decode + UART transmitter); slave: the FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          flush;
  logic          clr_overflow;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          busy;
  logic [7:0]    uart_data;
  logic          uart_send;
  logic          uart_ready;

  modport master (
    output wr_valid, wr_data, flush, clr_overflow, uart_ready,
    input  wr_ready, level, empty, full, overflow, busy, uart_data, uart_send
  );

  modport slave (
    input  wr_valid, wr_data, flush, clr_overflow, uart_ready,
    output wr_ready, level, empty, full, overflow, busy, uart_data, uart_send
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: bus pushes bytes, the drain FSM
// hands them to the UART one single-cycle send request at a time, ignoring
// uart_ready for GUARD cycles after each request while the UART's ready drops.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int GUARD = 2
) (
  input  logic            clk,
  input  logic            resetn,
  uart_tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? (GUARD - 1) : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic [1:0]    state;
  logic [CW-1:0] gcnt;
  logic          send_q;
  logic [7:0]    data_q;

  logic empty_w;
  logic full_w;
  logic push;
  logic pop;

  // Status comes from the registered level; full is judged before the edge,
  // so a push at full is refused even if a pop happens in the same cycle.
  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LW'(DEPTH));
  assign push    = bus.wr_valid && !full_w && !bus.flush;
  assign pop     = (state == ST_IDLE) && !empty_w && bus.uart_ready && !bus.flush;

  assign bus.level     = level_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.wr_ready  = !full_w;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state != ST_IDLE) || !empty_w;
  assign bus.uart_data = data_q;
  assign bus.uart_send = send_q;

  // Storage write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end

  // Pointers and occupancy count; flush empties the queue outright.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow flag; an explicit clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (bus.clr_overflow) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_valid && full_w) begin
      overflow_q <= 1'b1;
    end
  end

  // Drain FSM: pop in IDLE, blind GUARD window, then WAIT for ready again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      gcnt   <= '0;
      send_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      send_q <= pop;
      if (pop) data_q <= mem[rptr];
      case (state)
        ST_IDLE: begin
          if (pop) begin
            gcnt  <= '0;
            state <= (GUARD == 0) ? ST_WAIT : ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (gcnt == GUARD_LAST) state <= ST_WAIT;
          else                    gcnt  <= gcnt + CW'(1);
        end
        ST_WAIT: begin
          if (bus.uart_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a table of hand-computed vectors plus directed and
// random sequences, all checked every cycle against a queue-based model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int GUARD = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_if ();

  uart_tx_fifo #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO as a queue; transmitter availability as a rule:
  // after a send, the next send may only follow a ready cycle that is at
  // least GUARD+1 cycles after the send.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_send;
  bit         m_idle;
  int         m_since;
  logic [7:0] m_data;

  logic [7:0] got[$];
  int         peak_level;

  typedef struct {
    logic          wv;
    logic [7:0]    wd;
    logic          fl;
    logic          clr;
    logic          rdy;
    logic [LW-1:0] e_level;
    logic          e_send;
    logic [7:0]    e_data;
    logic          e_busy;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_send  = 1'b0;
    m_idle  = 1'b1;
    m_since = 0;
    m_data  = 8'h00;
  endtask

  function automatic bit m_busy();
    return !m_idle || (mq.size() != 0);
  endfunction

  // Advance the model over one clock edge using the inputs now driven.
  task automatic model_edge();
    bit was_full;
    bit do_pop;
    was_full = (mq.size() == DEPTH);
    do_pop   = m_idle && (mq.size() > 0) && (bus_if.uart_ready === 1'b1) && !bus_if.flush;
    if (bus_if.clr_overflow)              m_ovf = 1'b0;
    else if (bus_if.wr_valid && was_full) m_ovf = 1'b1;
    if (!m_idle) begin
      if (m_since >= GUARD && bus_if.uart_ready) m_idle = 1'b1;
      m_since++;
    end
    if (bus_if.flush) begin
      mq.delete();
    end else begin
      if (do_pop) m_data = mq.pop_front();
      if (bus_if.wr_valid && !was_full) mq.push_back(bus_if.wr_data);
    end
    if (do_pop) begin
      m_idle  = 1'b0;
      m_since = 0;
    end
    m_send = do_pop;
  endtask

  task automatic compare_all();
    int sz;
    sz = mq.size();
    check("level",     bus_if.level,     sz);
    check("empty",     bus_if.empty,     sz == 0);
    check("full",      bus_if.full,      sz == DEPTH);
    check("wr_ready",  bus_if.wr_ready,  sz != DEPTH);
    check("overflow",  bus_if.overflow,  m_ovf);
    check("uart_send", bus_if.uart_send, m_send);
    check("uart_data", bus_if.uart_data, m_data);
    check("busy",      bus_if.busy,      m_busy());
    if (bus_if.uart_send === 1'b1) begin
      got.push_back(bus_if.uart_data);
      $display("tx byte 0x%02h level %0d t=%0t", bus_if.uart_data, bus_if.level, $time);
    end
    if (int'(bus_if.level) > peak_level) peak_level = int'(bus_if.level);
  endtask

  // One clock: drive inputs, step the model, sample at the falling edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic fl,
                      input logic clr, input logic rdy);
    bus_if.wr_valid     = wv;
    bus_if.wr_data      = wd;
    bus_if.flush        = fl;
    bus_if.clr_overflow = clr;
    bus_if.uart_ready   = rdy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    i = 0;
    while (m_busy() && i < budget) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      i++;
    end
    check(name, bus_if.busy, 1'b0);
  endtask

  initial begin
    int base;
    int ucnt;
    int next;
    logic [7:0] msg[3];

    tbl[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 8'h48, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 8'h48, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 8'h48, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'h48, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 8'h48, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 8'h69, 1'b1};
    tbl[8]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 8'h69, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h69, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h69, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h69, 1'b0};

    bus_if.wr_valid     = 1'b0;
    bus_if.wr_data      = 8'h00;
    bus_if.flush        = 1'b0;
    bus_if.clr_overflow = 1'b0;
    bus_if.uart_ready   = 1'b1;
    model_reset();
    peak_level = 0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_level",    bus_if.level,     0);
    check("rst_empty",    bus_if.empty,     1);
    check("rst_full",     bus_if.full,      0);
    check("rst_wr_ready", bus_if.wr_ready,  1);
    check("rst_overflow", bus_if.overflow,  0);
    check("rst_send",     bus_if.uart_send, 0);
    check("rst_data",     bus_if.uart_data, 0);
    check("rst_busy",     bus_if.busy,      0);
    resetn = 1'b1;

    // Idle with ready high: nothing may be sent.
    base = got.size();
    for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("idle_no_send", got.size() - base, 0);

    // Hand-computed vector table: send pacing, flush with push, data hold.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].clr, tbl[i].rdy);
      check($sformatf("tbl%0d_level", i), bus_if.level,     tbl[i].e_level);
      check($sformatf("tbl%0d_send", i),  bus_if.uart_send, tbl[i].e_send);
      check($sformatf("tbl%0d_data", i),  bus_if.uart_data, tbl[i].e_data);
      check($sformatf("tbl%0d_busy", i),  bus_if.busy,      tbl[i].e_busy);
    end

    // Three bytes through a slow UART (ready low 40 cycles per byte).
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    base = got.size();
    peak_level = 0;
    ucnt = 40;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, msg[i], 1'b0, 1'b0, ucnt == 0);
      if (bus_if.uart_send === 1'b1) ucnt = 40; else if (ucnt > 0) ucnt--;
    end
    for (int i = 0; i < 400 && (m_busy() || ucnt != 0); i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, ucnt == 0);
      if (bus_if.uart_send === 1'b1) ucnt = 40; else if (ucnt > 0) ucnt--;
    end
    check("msg_count", got.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < got.size()) check($sformatf("msg_byte%0d", i), got[base + i], msg[i]);
    check("msg_peak_ok", (peak_level >= 2 && peak_level <= 3), 1);
    check("msg_level_end", bus_if.level, 0);
    check("msg_busy_end", bus_if.busy, 0);

    // Fill past full with ready held low.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("fill_full", bus_if.full, 1);
    check("fill_wr_ready", bus_if.wr_ready, 0);
    check("fill_ovf_before", bus_if.overflow, 0);
    step(1'b1, 8'd16, 1'b0, 1'b0, 1'b0);
    check("fill_ovf", bus_if.overflow, 1);
    check("fill_level", bus_if.level, 16);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("fill_clr", bus_if.overflow, 0);
    base = got.size();
    drain(200, "fill_drain");
    check("fill_count", got.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (base + i < got.size()) check($sformatf("fill_byte%0d", i), got[base + i], i);

    // Full + pop + push in one cycle: push refused, overflow set.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("fullpop_send", bus_if.uart_send, 1);
    check("fullpop_level", bus_if.level, 15);
    check("fullpop_ovf", bus_if.overflow, 1);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    check("clr_wins_ovf", bus_if.overflow, 0);
    check("clr_wins_level", bus_if.level, 16);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("flush_level", bus_if.level, 0);
    drain(50, "flush_idle");

    // Level 3: push and pop together keep the level.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    check("pushpop_send", bus_if.uart_send, 1);
    check("pushpop_level", bus_if.level, 3);
    drain(100, "pushpop_drain");

    // Flush while a byte is mid-send with 5 queued.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("midsend_send", bus_if.uart_send, 1);
    check("midsend_level", bus_if.level, 5);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    check("midflush_level", bus_if.level, 0);
    base = got.size();
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("midflush_no_send", got.size() - base, 0);

    // Pointer wrap: 40 incrementing bytes, random ready.
    base = got.size();
    next = 0;
    for (int i = 0; i < 3000 && (next < 40 || m_busy()); i++) begin
      if (next < 40 && ($urandom % 4 != 0) && mq.size() < DEPTH) begin
        step(1'b1, 8'(next), 1'b0, 1'b0, 1'($urandom % 2));
        next++;
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom % 2));
      end
    end
    check("wrap_count", got.size() - base, 40);
    for (int i = 0; i < 40; i++)
      if (base + i < got.size()) check($sformatf("wrap_byte%0d", i), got[base + i], i);
    check("wrap_ovf", bus_if.overflow, 0);

    // Fully random traffic against the model.
    for (int i = 0; i < 500; i++)
      step(1'($urandom % 3 != 0), 8'($urandom), 1'($urandom % 40 == 0),
           1'($urandom % 25 == 0), 1'($urandom % 2));
    drain(100, "rand_drain");

    // Asynchronous reset mid-transmission.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    check("arst_pre_send", bus_if.uart_send, 1);
    #1 resetn = 1'b0;
    #1;
    model_reset();
    check("arst_level", bus_if.level, 0);
    check("arst_send", bus_if.uart_send, 0);
    check("arst_data", bus_if.uart_data, 0);
    check("arst_busy", bus_if.busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    base = got.size();
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("arst_no_send", got.size() - base, 0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    drain(50, "arst_drain");
    check("arst_after_byte", (got.size() > base) ? int'(got[got.size() - 1]) : -1, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
